// File: rtl/beta_wb_arbiter.sv
// Regfile write-port arbiter: one holding slot each for ALU and LSU writeback,
// one registered write per cycle. Optional starvation guard: BETA_WB_STARVE_GUARD_EN.
module beta_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxStarve = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_req_i,
  input  logic [4:0]           alu_rd_addr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  output logic                 alu_rdy_o,
  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_rd_addr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_rdy_o,
  output logic                 rf_wr_en_o,
  output logic [4:0]           rf_rd_addr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 wb_busy_o
);

  // The saturating 3-bit counter can only reach a threshold of 7.
  if (MaxStarve < 1 || MaxStarve > 8) begin : g_bad_max_starve
    $error("beta_wb_arbiter: MaxStarve must be in 1..8");
  end

  typedef enum logic [1:0] {
    GntNone,
    GntAlu,
    GntLsu
  } gnt_e;

  // young: this entry was filled after the other slot's entry (same-rd ordering).
  typedef struct packed {
    logic                 full;
    logic                 young;
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } slot_t;

  slot_t alu_q, alu_d;
  slot_t lsu_q, lsu_d;
  gnt_e  gnt;
  logic  alu_gnt, lsu_gnt;
  logic  alu_fill, lsu_fill;
  logic  alu_keep, lsu_keep;
  logic  starve_force;

`ifdef BETA_WB_STARVE_GUARD_EN
  localparam logic [2:0] StarveLimit = 3'(MaxStarve - 1);

  logic [2:0] starve_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= 3'd0;
    end else if (alu_q.full && !alu_gnt) begin
      starve_q <= (starve_q == 3'd7) ? starve_q : starve_q + 3'd1;
    end else begin
      starve_q <= 3'd0;
    end
  end

  assign starve_force = (starve_q >= StarveLimit);
`else
  assign starve_force = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = GntNone;
    if (alu_q.full && lsu_q.full) begin
      if (alu_q.addr == lsu_q.addr) begin
        gnt = lsu_q.young ? GntAlu : GntLsu;
      end else begin
        gnt = starve_force ? GntAlu : GntLsu;
      end
    end else if (alu_q.full) begin
      gnt = GntAlu;
    end else if (lsu_q.full) begin
      gnt = GntLsu;
    end
  end

  assign alu_gnt   = (gnt == GntAlu);
  assign lsu_gnt   = (gnt == GntLsu);
  assign alu_rdy_o = !alu_q.full || alu_gnt;
  assign lsu_rdy_o = !lsu_q.full || lsu_gnt;
  assign wb_busy_o = alu_q.full || lsu_q.full;

  // Writes to x0 are accepted but never occupy a slot.
  assign alu_fill = alu_req_i && alu_rdy_o && (alu_rd_addr_i != 5'd0);
  assign lsu_fill = lsu_req_i && lsu_rdy_o && (lsu_rd_addr_i != 5'd0);
  assign alu_keep = alu_q.full && !alu_gnt;
  assign lsu_keep = lsu_q.full && !lsu_gnt;

  always_comb begin
    alu_d = alu_q;
    if (alu_gnt) alu_d.full = 1'b0;
    if (alu_fill) begin
      alu_d.full = 1'b1;
      alu_d.addr = alu_rd_addr_i;
      alu_d.data = alu_wdata_i;
    end
    alu_d.young = alu_fill && lsu_keep;

    lsu_d = lsu_q;
    if (lsu_gnt) lsu_d.full = 1'b0;
    if (lsu_fill) begin
      lsu_d.full = 1'b1;
      lsu_d.addr = lsu_rd_addr_i;
      lsu_d.data = lsu_wdata_i;
    end
    lsu_d.young = lsu_fill && alu_keep;
  end

  // NOTE: slot payloads are reset along with the flags; they are only a few flops and a clean reset state keeps outputs deterministic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_q <= '0;
      lsu_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      alu_q <= alu_d;
      lsu_q <= lsu_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_wr_en_o   <= 1'b0;
      rf_rd_addr_o <= 5'd0;
      rf_wdata_o   <= '0;
    end else begin
      rf_wr_en_o <= (gnt != GntNone);
      if (alu_gnt) begin
        rf_rd_addr_o <= alu_q.addr;
        rf_wdata_o   <= alu_q.data;
      end else if (lsu_gnt) begin
        rf_rd_addr_o <= lsu_q.addr;
        rf_wdata_o   <= lsu_q.data;
      end
    end
  end

endmodule

// File: tb/tb_beta_wb_arbiter.sv
// Self-checking bench for beta_wb_arbiter: directed vector table, reset and
// starvation sequences, then random traffic against a timestamp-based model.
module tb_beta_wb_arbiter;

  localparam int MaxStarve = 4;
`ifdef BETA_WB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_req_i;
  logic [4:0]  alu_rd_addr_i;
  logic [31:0] alu_wdata_i;
  logic        alu_rdy_o;
  logic        lsu_req_i;
  logic [4:0]  lsu_rd_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_rdy_o;
  logic        rf_wr_en_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_wdata_o;
  logic        wb_busy_o;

  beta_wb_arbiter #(.DataWidth(32), .MaxStarve(MaxStarve)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alu_req_i    (alu_req_i),
    .alu_rd_addr_i(alu_rd_addr_i),
    .alu_wdata_i  (alu_wdata_i),
    .alu_rdy_o    (alu_rdy_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_rd_addr_i(lsu_rd_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_rdy_o    (lsu_rdy_o),
    .rf_wr_en_o   (rf_wr_en_o),
    .rf_rd_addr_o (rf_rd_addr_o),
    .rf_wdata_o   (rf_wdata_o),
    .wb_busy_o    (wb_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference model: each pending write carries the cycle number it arrived in.
  typedef struct {
    bit          v;
    logic [4:0]  addr;
    logic [31:0] data;
    int          stamp;
  } mslot_t;

  mslot_t      m_alu, m_lsu;
  int          m_cyc, m_starve;
  logic        m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic m_reset();
    m_alu = '{0, 5'd0, 32'd0, 0};
    m_lsu = '{0, 5'd0, 32'd0, 0};
    m_cyc = 0;
    m_starve = 0;
    m_wr = 0;
    m_addr = 5'd0;
    m_data = 32'd0;
  endtask

  // 0 = none, 1 = ALU, 2 = LSU
  function automatic int m_grant();
    if (m_alu.v && m_lsu.v) begin
      if (m_alu.addr == m_lsu.addr) return (m_alu.stamp < m_lsu.stamp) ? 1 : 2;
      if (Guard && m_starve >= MaxStarve - 1) return 1;
      return 2;
    end
    if (m_alu.v) return 1;
    if (m_lsu.v) return 2;
    return 0;
  endfunction

  task automatic m_step(input logic ar, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lr, input logic [4:0] la, input logic [31:0] ld);
    int  g;
    bit  ardy, lrdy;
    g = m_grant();
    ardy = !m_alu.v || g == 1;
    lrdy = !m_lsu.v || g == 2;
    if (m_alu.v && g != 1) m_starve = (m_starve >= 7) ? 7 : m_starve + 1;
    else m_starve = 0;
    m_wr = (g != 0);
    if (g == 1) begin
      m_addr = m_alu.addr; m_data = m_alu.data; m_alu.v = 0;
    end else if (g == 2) begin
      m_addr = m_lsu.addr; m_data = m_lsu.data; m_lsu.v = 0;
    end
    if (ar && ardy && aa != 5'd0) m_alu = '{1, aa, ad, m_cyc};
    if (lr && lrdy && la != 5'd0) m_lsu = '{1, la, ld, m_cyc};
    m_cyc++;
  endtask

  // One clock: drive at posedge+1, advance, compare against the model at posedge+1.
  task automatic do_cycle(input logic ar, input logic [4:0] aa, input logic [31:0] ad,
                          input logic lr, input logic [4:0] la, input logic [31:0] ld);
    int g;
    alu_req_i = ar; alu_rd_addr_i = aa; alu_wdata_i = ad;
    lsu_req_i = lr; lsu_rd_addr_i = la; lsu_wdata_i = ld;
    #1;
    m_step(ar, aa, ad, lr, la, ld);
    @(posedge clk_i);
    #1;
    g = m_grant();
    check("model.wr_en", 32'(rf_wr_en_o), 32'(m_wr));
    check("model.addr", 32'(rf_rd_addr_o), 32'(m_addr));
    check("model.data", rf_wdata_o, m_data);
    check("model.busy", 32'(wb_busy_o), 32'(m_alu.v || m_lsu.v));
    check("model.alu_rdy", 32'(alu_rdy_o), 32'(!m_alu.v || g == 1));
    check("model.lsu_rdy", 32'(lsu_rdy_o), 32'(!m_lsu.v || g == 2));
  endtask

  typedef struct {
    logic        ar;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lr;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        wr;
    logic [4:0]  oa;
    logic [31:0] od;
    logic        busy;
    logic        ardy;
    logic        lrdy;
  } vec_t;

  function automatic vec_t mk(logic ar, logic [4:0] aa, logic [31:0] ad,
                              logic lr, logic [4:0] la, logic [31:0] ld,
                              logic wr, logic [4:0] oa, logic [31:0] od,
                              logic busy, logic ardy, logic lrdy);
    return '{ar, aa, ad, lr, la, ld, wr, oa, od, busy, ardy, lrdy};
  endfunction

  vec_t vecs[25];

  initial begin
    int first;

    // Expected outputs are the values seen just after the edge that applies each row.
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,         0, 0, 32'h0,        1, 1, 1);
    vecs[1]  = mk(0, 0, 0,            0, 0, 0,         1, 5, 32'hDEADBEEF, 0, 1, 1);
    vecs[2]  = mk(0, 0, 0,            0, 0, 0,         0, 5, 32'hDEADBEEF, 0, 1, 1);
    vecs[3]  = mk(0, 0, 0,            1, 0, 32'h1234,  0, 5, 32'hDEADBEEF, 0, 1, 1);
    vecs[4]  = mk(0, 0, 0,            0, 0, 0,         0, 5, 32'hDEADBEEF, 0, 1, 1);
    vecs[5]  = mk(1, 3, 32'h11,       1, 7, 32'h22,    0, 5, 32'hDEADBEEF, 1, 0, 1);
    vecs[6]  = mk(0, 0, 0,            0, 0, 0,         1, 7, 32'h22,       1, 1, 1);
    vecs[7]  = mk(0, 0, 0,            0, 0, 0,         1, 3, 32'h11,       0, 1, 1);
    vecs[8]  = mk(0, 0, 0,            0, 0, 0,         0, 3, 32'h11,       0, 1, 1);
    vecs[9]  = mk(1, 9, 32'hA,        0, 0, 0,         0, 3, 32'h11,       1, 1, 1);
    vecs[10] = mk(0, 0, 0,            1, 9, 32'hB,     1, 9, 32'hA,        1, 1, 1);
    vecs[11] = mk(0, 0, 0,            0, 0, 0,         1, 9, 32'hB,        0, 1, 1);
    vecs[12] = mk(1, 9, 32'hD,        1, 6, 32'h66,    0, 9, 32'hB,        1, 0, 1);
    vecs[13] = mk(0, 0, 0,            1, 9, 32'hE,     1, 6, 32'h66,       1, 1, 0);
    vecs[14] = mk(0, 0, 0,            0, 0, 0,         1, 9, 32'hD,        1, 1, 1);
    vecs[15] = mk(0, 0, 0,            0, 0, 0,         1, 9, 32'hE,        0, 1, 1);
    vecs[16] = mk(0, 0, 0,            0, 0, 0,         0, 9, 32'hE,        0, 1, 1);
    vecs[17] = mk(1, 2, 32'h1,        1, 2, 32'h2,     0, 9, 32'hE,        1, 0, 1);
    vecs[18] = mk(0, 0, 0,            0, 0, 0,         1, 2, 32'h2,        1, 1, 1);
    vecs[19] = mk(0, 0, 0,            0, 0, 0,         1, 2, 32'h1,        0, 1, 1);
    vecs[20] = mk(1, 1, 32'h101,      0, 0, 0,         0, 2, 32'h1,        1, 1, 1);
    vecs[21] = mk(1, 1, 32'h102,      0, 0, 0,         1, 1, 32'h101,      1, 1, 1);
    vecs[22] = mk(1, 1, 32'h103,      0, 0, 0,         1, 1, 32'h102,      1, 1, 1);
    vecs[23] = mk(0, 0, 0,            0, 0, 0,         1, 1, 32'h103,      0, 1, 1);
    vecs[24] = mk(0, 0, 0,            0, 0, 0,         0, 1, 32'h103,      0, 1, 1);

    rst_i = 1'b1;
    alu_req_i = 0; alu_rd_addr_i = 0; alu_wdata_i = 0;
    lsu_req_i = 0; lsu_rd_addr_i = 0; lsu_wdata_i = 0;
    m_reset();
    #7;
    check("reset.wr_en", 32'(rf_wr_en_o), 32'd0);
    check("reset.addr", 32'(rf_rd_addr_o), 32'd0);
    check("reset.data", rf_wdata_o, 32'd0);
    check("reset.busy", 32'(wb_busy_o), 32'd0);
    check("reset.alu_rdy", 32'(alu_rdy_o), 32'd1);
    check("reset.lsu_rdy", 32'(lsu_rdy_o), 32'd1);
    #5 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 25; i++) begin
      do_cycle(vecs[i].ar, vecs[i].aa, vecs[i].ad, vecs[i].lr, vecs[i].la, vecs[i].ld);
      check($sformatf("vec%0d.wr_en", i), 32'(rf_wr_en_o), 32'(vecs[i].wr));
      check($sformatf("vec%0d.addr", i), 32'(rf_rd_addr_o), 32'(vecs[i].oa));
      check($sformatf("vec%0d.data", i), rf_wdata_o, vecs[i].od);
      check($sformatf("vec%0d.busy", i), 32'(wb_busy_o), 32'(vecs[i].busy));
      check($sformatf("vec%0d.alu_rdy", i), 32'(alu_rdy_o), 32'(vecs[i].ardy));
      check($sformatf("vec%0d.lsu_rdy", i), 32'(lsu_rdy_o), 32'(vecs[i].lrdy));
    end

    // Starvation: ALU parked on rd 12 while LSU streams to rd 13 for 8 cycles.
    first = -1;
    for (int i = 0; i < 12; i++) begin
      do_cycle(i == 0, 5'd12, 32'h77, i < 8, 5'd13, 32'h300 + 32'(i));
      if (first < 0 && rf_wr_en_o && rf_rd_addr_o == 5'd12) first = i;
    end
    check("starve.alu_issue_cycle", 32'(first), Guard ? 32'd4 : 32'd9);

    // Asynchronous reset mid-cycle with both slots holding writes.
    do_cycle(1, 5'd10, 32'hAA, 1, 5'd11, 32'hBB);
    #3 rst_i = 1'b1;
    #1;
    check("midrst.wr_en", 32'(rf_wr_en_o), 32'd0);
    check("midrst.addr", 32'(rf_rd_addr_o), 32'd0);
    check("midrst.data", rf_wdata_o, 32'd0);
    check("midrst.busy", 32'(wb_busy_o), 32'd0);
    check("midrst.alu_rdy", 32'(alu_rdy_o), 32'd1);
    check("midrst.lsu_rdy", 32'(lsu_rdy_o), 32'd1);
    alu_req_i = 0; lsu_req_i = 0;
    m_reset();
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 0, 0, 0, 0, 0);
      check($sformatf("postrst%0d.wr_en", i), 32'(rf_wr_en_o), 32'd0);
    end

    // Random traffic over a small address set so same-rd collisions are frequent.
    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 3)), $urandom,
               $urandom_range(0, 9) < 6, 5'($urandom_range(0, 3)), $urandom);
    end
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0, 0, 0);
    check("drain.busy", 32'(wb_busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
